fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch bus between fetch_ctrl and the instruction memory.
//   imem_req   : fetch request (fetch side -> memory)
//   imem_addr  : fetch address (fetch side -> memory)
//   imem_ready : response for imem_addr valid this cycle (memory -> fetch side)
//   imem_rdata : fetched instruction, valid with imem_ready (memory -> fetch side)
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: owns the PC, drives the instruction-memory bus and
// loads the IF/ID pipeline register, honouring load-use stalls and redirects.
// A redirect that arrives while a fetch is still outstanding parks the target
// and enters KILL until the stale response returns and is dropped.
// Optional feature macro: FETCH_PERF_CNT_EN (redirect/stall performance counters).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   is_stall[1:0] : bit1 redirect, bit0 load-use stall
//   pc_branch     : redirect target, valid with is_stall[1]
//   imem          : instruction fetch bus (master side)
//   if_id_pc/instr/valid : IF/ID pipeline register
//   id_ex_bubble  : combinational, ID/EX must load a bubble this cycle
//   redirect_cnt, stall_cnt : performance counters (zero when feature disabled)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          is_stall,
  input  logic [31:0]         pc_branch,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic                if_id_valid,
  output logic                id_ex_bubble,
  output logic [31:0]         redirect_cnt,
  output logic [31:0]         stall_cnt
);
  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {FETCH, KILL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] ifid_pc_d, ifid_instr_d;
  logic            ifid_valid_d;
  logic            redirect, load_stall;

  assign redirect   = is_stall[1];
  assign load_stall = is_stall[0] & ~is_stall[1];

  // Request is asserted in every non-reset cycle; address is the PC register.
  assign imem.imem_req  = ~rst;
  assign imem.imem_addr = pc_q;

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      if_id_pc    <= ifid_pc_d;
      if_id_instr <= ifid_instr_d;
      if_id_valid <= ifid_valid_d;
    end
  end

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_pc_d    = if_id_pc;
    ifid_instr_d = if_id_instr;
    ifid_valid_d = if_id_valid;
    id_ex_bubble = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          id_ex_bubble = 1'b1;
          ifid_pc_d    = pc_branch;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (imem.imem_ready) begin
            pc_d = pc_branch;
          end else begin
            // Fetch still in flight: keep the address stable, park the target.
            tgt_d   = pc_branch;
            state_d = KILL;
          end
        end else if (load_stall) begin
          // Hold PC and IF/ID; any returned data is dropped and re-fetched.
          id_ex_bubble = 1'b1;
        end else if (imem.imem_ready) begin
          pc_d         = pc_q + XLEN'(PC_STEP);
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem.imem_rdata;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      KILL: begin
        // Stale response is discarded; load-use stall has no effect here.
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        if (redirect) begin
          id_ex_bubble = 1'b1;
          tgt_d        = pc_branch;
        end
        if (imem.imem_ready) begin
          pc_d    = tgt_d;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] redirect_cnt_q, stall_cnt_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect) begin
        redirect_cnt_q <= redirect_cnt_q + XLEN'(1);
      end
      if (load_stall && (state_q == FETCH)) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural model predicts each cycle's
// outcome, pushes it to a scoreboard queue, and the entry is popped and compared
// after the clock edge. Directed checks cover the documented scenarios.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        ifvalid;
    logic [31:0] rc;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  is_stall;
  logic [31:0] pc_branch;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid, id_ex_bubble;
  logic [31:0] redirect_cnt, stall_cnt;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk          (clk),
    .rst          (rst),
    .is_stall     (is_stall),
    .pc_branch    (pc_branch),
    .imem         (bus),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .id_ex_bubble (id_ex_bubble),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model state.
  logic [31:0] m_pc, m_tgt, m_ifpc, m_ifinstr, m_rc, m_sc;
  logic        m_ifvalid, m_kill;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, predict, clock, compare.
  task automatic cycle(input logic r, input logic [1:0] st, input logic [31:0] br,
                       input logic rdy, input logic [31:0] rd);
    exp_t e;
    logic exp_bubble;
    rst = r; is_stall = st; pc_branch = br;
    bus.imem_ready = rdy; bus.imem_rdata = rd;
    #1;
    exp_bubble = !r && (st[1] || (!m_kill && st == 2'b01));
    check("bubble", 32'(id_ex_bubble), 32'(exp_bubble));
    check("req", 32'(bus.imem_req), 32'(!r));
    check("addr_pre", bus.imem_addr, m_pc);

    if (r) begin
      m_pc = RESET_PC; m_tgt = '0; m_kill = 1'b0;
      m_ifpc = '0; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      m_rc = '0; m_sc = '0;
    end else if (!m_kill) begin
      if (st[1]) begin
        m_rc++;
        m_ifpc = br; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
        if (rdy) m_pc = br;
        else begin m_kill = 1'b1; m_tgt = br; end
      end else if (st[0]) begin
        m_sc++;
      end else if (rdy) begin
        m_ifpc = m_pc; m_ifinstr = rd; m_ifvalid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_ifpc = m_pc; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      end
    end else begin
      m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      if (st[1]) begin m_rc++; m_tgt = br; end
      if (rdy) begin m_kill = 1'b0; m_pc = m_tgt; end
    end

    e.addr = m_pc; e.ifpc = m_ifpc; e.ifinstr = m_ifinstr; e.ifvalid = m_ifvalid;
`ifdef FETCH_PERF_CNT_EN
    e.rc = m_rc; e.sc = m_sc;
`else
    e.rc = '0; e.sc = '0;
`endif
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("imem_addr", bus.imem_addr, e.addr);
    check("if_id_pc", if_id_pc, e.ifpc);
    check("if_id_instr", if_id_instr, e.ifinstr);
    check("if_id_valid", 32'(if_id_valid), 32'(e.ifvalid));
    check("redirect_cnt", redirect_cnt, e.rc);
    check("stall_cnt", stall_cnt, e.sc);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'h0, 1'b1, 32'hA000_0000 | $urandom_range(0, 255));
  endtask

  initial begin
    logic [31:0] ifpc_save, ifinstr_save, sc_save, rc_save;
    m_pc = RESET_PC; m_tgt = '0; m_kill = 1'b0;
    m_ifpc = '0; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0; m_rc = '0; m_sc = '0;
    rst = 1'b1; is_stall = 2'b00; pc_branch = '0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    @(posedge clk); #1;

    // Reset state.
    cycle(1'b1, 2'b00, 32'h0, 1'b1, 32'h0);
    check("rst_pc", bus.imem_addr, RESET_PC);
    check("rst_instr", if_id_instr, NOP_INSTR);
    check("rst_valid", 32'(if_id_valid), 32'h0);

    // Straight-line fetch from reset.
    cycle(1'b0, 2'b00, 32'h0, 1'b1, 32'h1111_0001);
    check("seq_addr1", bus.imem_addr, 32'h4);
    check("seq_ifpc0", if_id_pc, 32'h0);
    cycle(1'b0, 2'b00, 32'h0, 1'b1, 32'h1111_0002);
    check("seq_addr2", bus.imem_addr, 32'h8);
    check("seq_ifpc1", if_id_pc, 32'h4);
    check("seq_valid", 32'(if_id_valid), 32'h1);
    fetch(2);

    // Load-use stall at 0x10 for two cycles.
    check("stall_pc0", bus.imem_addr, 32'h10);
    ifpc_save = if_id_pc; ifinstr_save = if_id_instr;
    cycle(1'b0, 2'b01, 32'h0, 1'b1, 32'hDEAD_0001);
    cycle(1'b0, 2'b01, 32'h0, 1'b1, 32'hDEAD_0002);
    check("stall_pc", bus.imem_addr, 32'h10);
    check("stall_ifpc", if_id_pc, ifpc_save);
    check("stall_ifinstr", if_id_instr, ifinstr_save);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt2", stall_cnt, 32'd2);
`endif

    // Fetch stalled by a not-ready memory.
    cycle(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    fetch(4);

    // Redirect with ready at 0x20.
    check("redir_pc0", bus.imem_addr, 32'h20);
    cycle(1'b0, 2'b10, 32'h100, 1'b1, 32'hBAD0_0000);
    check("redir_addr", bus.imem_addr, 32'h100);
    check("redir_valid", 32'(if_id_valid), 32'h0);

    // Redirect while fetch outstanding: KILL holds the old address.
    cycle(1'b0, 2'b10, 32'h20, 1'b1, 32'h0);
    cycle(1'b0, 2'b10, 32'h200, 1'b0, 32'h0);
    cycle(1'b0, 2'b01, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    check("kill_hold", bus.imem_addr, 32'h20);
    cycle(1'b0, 2'b00, 32'h0, 1'b1, 32'hBAD0_0001);
    check("kill_drop", 32'(if_id_valid), 32'h0);
    check("kill_exit", bus.imem_addr, 32'h200);
    fetch(1);

    // Second redirect in KILL overwrites the parked target.
    cycle(1'b0, 2'b10, 32'h300, 1'b0, 32'h0);
    cycle(1'b0, 2'b10, 32'h400, 1'b0, 32'h0);
    cycle(1'b0, 2'b00, 32'h0, 1'b1, 32'h0);
    check("kill_ovr", bus.imem_addr, 32'h400);

    // Simultaneous redirect and load-use stall.
    sc_save = stall_cnt; rc_save = redirect_cnt;
    cycle(1'b0, 2'b11, 32'h500, 1'b1, 32'h0);
    check("both_addr", bus.imem_addr, 32'h500);
    check("both_sc", stall_cnt, sc_save);
`ifdef FETCH_PERF_CNT_EN
    check("both_rc", redirect_cnt, rc_save + 32'd1);
`endif

    // PC wrap.
    cycle(1'b0, 2'b10, 32'hFFFF_FFFC, 1'b1, 32'h0);
    fetch(1);
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

    // Reset in the middle of KILL.
    cycle(1'b0, 2'b10, 32'h600, 1'b0, 32'h0);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    check("rst_kill", bus.imem_addr, RESET_PC);
    fetch(1);
    check("rst_kill_next", bus.imem_addr, RESET_PC + 32'd4);

    // Random mix against the model.
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
